// File: rtl/carregador_programa_pkg.sv
// Shared definitions for the boot-time program loader: state encoding and the
// default widths used by the instruction memory and the core.
package carregador_programa_pkg;

  localparam int unsigned LARGURA_DADO_PADRAO = 8;
  localparam int unsigned LARGURA_END_PADRAO  = 8;

  typedef enum logic [2:0] {
    StOcioso  = 3'd0,
    StCarrega = 3'd1,
    StCheca   = 3'd2,
    StExecuta = 3'd3,
    StErro    = 3'd4
  } estado_e;

endpackage

// File: rtl/carregador_programa_acumulador_checksum.sv
// Modular byte accumulator: soma wraps at 2^LARGURA_DADO, cleared at load start.
module acumulador_checksum #(
  parameter int unsigned LARGURA_DADO = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [LARGURA_DADO-1:0] dado,
  output logic [LARGURA_DADO-1:0] soma
);

  logic [LARGURA_DADO-1:0] soma_q;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      soma_q <= '0;
    end else if (enable) begin
      soma_q <= soma_q + dado;
    end
  end

  assign soma = soma_q;

endmodule

// File: rtl/carregador_programa.sv
// Loads a byte stream into instruction memory from address 0, verifies a trailing
// two's-complement checksum and holds the core until a load succeeds.
module carregador_programa
  import carregador_programa_pkg::*;
#(
  parameter int unsigned LARGURA_DADO = LARGURA_DADO_PADRAO,
  parameter int unsigned LARGURA_END  = LARGURA_END_PADRAO,
  parameter bit          USA_CHECKSUM = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    carregar,
  input  logic [LARGURA_END-1:0]  comprimento,
  input  logic                    in_valid,
  input  logic [LARGURA_DADO-1:0] in_data,
  output logic                    in_ready,
  output logic                    mem_escreve,
  output logic [LARGURA_END-1:0]  mem_endereco,
  output logic [LARGURA_DADO-1:0] mem_dado,
  output logic                    segura_cpu,
  output logic                    pronto,
  output logic                    erro
);

  localparam logic [LARGURA_END-1:0] Um = 1;

  estado_e                 estado_q, estado_d;
  logic [LARGURA_END-1:0]  ptr_q, ptr_d;
  logic [LARGURA_END-1:0]  restante_q, restante_d;
  logic [LARGURA_DADO-1:0] soma, soma_final;
  logic                    transfer, limpa_soma, soma_en;

  assign in_ready   = (estado_q == StCarrega) || (estado_q == StCheca);
  assign transfer   = in_valid && in_ready;
  assign soma_final = soma + in_data;

  acumulador_checksum #(
    .LARGURA_DADO (LARGURA_DADO)
  ) u_acumulador (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (limpa_soma),
    .enable (soma_en),
    .dado   (in_data),
    .soma   (soma)
  );

  always_comb begin
    estado_d   = estado_q;
    ptr_d      = ptr_q;
    restante_d = restante_q;
    limpa_soma = 1'b0;
    soma_en    = 1'b0;
    unique case (estado_q)
      StOcioso, StExecuta, StErro: begin
        if (carregar) begin
          restante_d = comprimento;
          ptr_d      = '0;
          limpa_soma = 1'b1;
          estado_d   = (comprimento == '0) ? StExecuta : StCarrega;
        end
      end
      StCarrega: begin
        if (transfer) begin
          ptr_d      = ptr_q + Um;
          restante_d = restante_q - Um;
          soma_en    = 1'b1;
          if (restante_q == Um) begin
            estado_d = USA_CHECKSUM ? StCheca : StExecuta;
          end
        end
      end
      StCheca: begin
        if (transfer) begin
          estado_d = (soma_final == '0) ? StExecuta : StErro;
        end
      end
      default: estado_d = StOcioso;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      estado_q     <= StOcioso;
      ptr_q        <= '0;
      restante_q   <= '0;
      mem_escreve  <= 1'b0;
      mem_endereco <= '0;
      mem_dado     <= '0;
      segura_cpu   <= 1'b1;
      pronto       <= 1'b0;
      erro         <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      ptr_q       <= ptr_d;
      restante_q  <= restante_d;
      mem_escreve <= transfer && (estado_q == StCarrega);
      if (transfer && (estado_q == StCarrega)) begin
        mem_endereco <= ptr_q;
        mem_dado     <= in_data;
      end
      segura_cpu <= (estado_d != StExecuta);
      pronto     <= (estado_d == StExecuta);
      erro       <= (estado_d == StErro);
    end
  end

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench for carregador_programa: directed scenarios plus randomized
// loads compared against a list-of-writes / checksum-sum reference model.
module tb_carregador_programa;

  logic       CLK = 1'b0;
  logic       RST;
  logic       carregar;
  logic [7:0] comprimento;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_escreve;
  logic [7:0] mem_endereco;
  logic [7:0] mem_dado;
  logic       segura_cpu;
  logic       pronto;
  logic       erro;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        captured[$];
  logic [7:0] carga[$];
  int         gaps[$];

  always #5 CLK = ~CLK;

  carregador_programa dut (
    .CLK          (CLK),
    .RST          (RST),
    .carregar     (carregar),
    .comprimento  (comprimento),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_escreve  (mem_escreve),
    .mem_endereco (mem_endereco),
    .mem_dado     (mem_dado),
    .segura_cpu   (segura_cpu),
    .pronto       (pronto),
    .erro         (erro)
  );

  always @(negedge CLK) begin
    if (mem_escreve === 1'b1) captured.push_back('{mem_endereco, mem_dado});
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one load of carga[] followed by checksum ck, with gaps[i] idle cycles
  // before stream byte i; the model is the write list plus the modular byte sum.
  task automatic do_load(input logic [7:0] ck, input bit poke);
    int len;
    int sum;
    bit ok;
    int nbytes;
    logic [7:0] b;
    len = carga.size();
    sum = 0;
    captured.delete();
    carregar = 1'b1;
    comprimento = len[7:0];
    tick();
    carregar = 1'b0;
    checks++;
    if (erro !== 1'b0 || pronto !== (len == 0) || segura_cpu !== (len != 0)) begin
      failures++;
      $display("FAIL load_entry: erro=%b pronto=%b segura=%b required 0 %b %b",
               erro, pronto, segura_cpu, len == 0, len != 0);
    end
    nbytes = (len == 0) ? 0 : len + 1;
    for (int i = 0; i < nbytes; i++) begin
      b = (i < len) ? carga[i] : ck;
      if (i < len) sum += carga[i];
      for (int g = 0; g < ((i < gaps.size()) ? gaps[i] : 0); g++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (poke) begin
          carregar = 1'b1;
          comprimento = 8'($urandom);
        end
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL gap_ready: byte %0d in_ready=%b required 1", i, in_ready);
        end
        tick();
        carregar = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = b;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL byte_ready: byte %0d in_ready=%b required 1", i, in_ready);
      end
      tick();
      in_valid = 1'b0;
    end
    ok = (len == 0) || (((sum + ck) % 256) == 0);
    checks++;
    if (pronto !== ok || erro !== !ok || segura_cpu !== !ok || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_result: pronto=%b erro=%b segura=%b in_ready=%b required %b %b %b 0",
               pronto, erro, segura_cpu, in_ready, ok, !ok, !ok);
    end
    tick();
    checks++;
    if (captured.size() != len) begin
      failures++;
      $display("FAIL write_count: got %0d required %0d", captured.size(), len);
    end
    for (int i = 0; i < len && i < captured.size(); i++) begin
      checks++;
      if (captured[i].a !== i[7:0] || captured[i].d !== carga[i]) begin
        failures++;
        $display("FAIL write_%0d: got (%0d,%h) required (%0d,%h)",
                 i, captured[i].a, captured[i].d, i, carga[i]);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    carregar = 1'b0;
    comprimento = '0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) tick();
    checks++;
    if (segura_cpu !== 1'b1 || pronto !== 1'b0 || erro !== 1'b0 || in_ready !== 1'b0 ||
        mem_escreve !== 1'b0 || mem_endereco !== 8'h00 || mem_dado !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: segura=%b pronto=%b erro=%b rdy=%b we=%b a=%h d=%h required 1 0 0 0 0 00 00",
               segura_cpu, pronto, erro, in_ready, mem_escreve, mem_endereco, mem_dado);
    end
    RST = 1'b0;
    captured.delete();
    in_valid = 1'b1;
    in_data = 8'h5A;
    repeat (3) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL idle_ready: got %b required 0", in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (captured.size() != 0 || segura_cpu !== 1'b1) begin
      failures++;
      $display("FAIL idle_writes: writes=%0d segura=%b required 0 1", captured.size(), segura_cpu);
    end
  endtask

  task automatic test_basic_load();
    carga = '{8'h21, 8'h42, 8'h63};
    gaps = '{};
    do_load(8'h3A, 1'b0);
  endtask

  task automatic test_bad_checksum();
    carga = '{8'h21, 8'h42, 8'h63};
    gaps = '{};
    do_load(8'h3B, 1'b0);
    do_load(8'h3A, 1'b0);
  endtask

  task automatic test_gaps();
    carga = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    gaps = '{0, 2, 0, 1, 0};
    do_load(8'($unsigned(256 - ((8'hA1 + 8'hB2 + 8'hC3 + 8'hD4) % 256))), 1'b1);
  endtask

  task automatic test_zero_len();
    carga = '{};
    gaps = '{};
    do_load(8'h00, 1'b0);
    in_valid = 1'b1;
    repeat (3) begin
      checks++;
      if (in_ready !== 1'b0 || pronto !== 1'b1) begin
        failures++;
        $display("FAIL zero_len_hold: in_ready=%b pronto=%b required 0 1", in_ready, pronto);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (captured.size() != 0) begin
      failures++;
      $display("FAIL zero_len_writes: got %0d required 0", captured.size());
    end
  endtask

  task automatic test_rst_wins();
    RST = 1'b1;
    carregar = 1'b1;
    comprimento = 8'h00;
    tick();
    RST = 1'b0;
    carregar = 1'b0;
    checks++;
    if (pronto !== 1'b0 || segura_cpu !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_wins: pronto=%b segura=%b rdy=%b required 0 1 0",
               pronto, segura_cpu, in_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    captured.delete();
    carregar = 1'b1;
    comprimento = 8'd4;
    tick();
    carregar = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h77;
    tick();
    in_data = 8'h88;
    tick();
    in_valid = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (segura_cpu !== 1'b1 || in_ready !== 1'b0 || pronto !== 1'b0 || mem_escreve !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: segura=%b rdy=%b pronto=%b we=%b required 1 0 0 0",
               segura_cpu, in_ready, pronto, mem_escreve);
    end
    in_valid = 1'b1;
    in_data = 8'h99;
    repeat (2) tick();
    in_valid = 1'b0;
    checks++;
    if (captured.size() != 2 || captured[0].a !== 8'd0 || captured[1].a !== 8'd1 ||
        captured[1].d !== 8'h88) begin
      failures++;
      $display("FAIL mid_reset_writes: count=%0d required 2 at 0,1", captured.size());
    end
    carga = '{8'h11, 8'h22};
    gaps = '{};
    do_load(8'hCD, 1'b0);
  endtask

  task automatic test_max_len();
    int sum;
    sum = 0;
    carga = '{};
    gaps = '{};
    for (int i = 0; i < 255; i++) begin
      carga.push_back(8'($urandom));
      sum += carga[i];
    end
    do_load(8'((256 - (sum % 256)) % 256), 1'b0);
  endtask

  task automatic test_random();
    int len;
    int sum;
    logic [7:0] ck;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 12);
      sum = 0;
      carga = '{};
      gaps = '{};
      for (int i = 0; i < len; i++) begin
        carga.push_back(8'($urandom));
        sum += carga[i];
      end
      for (int i = 0; i <= len; i++) gaps.push_back($urandom_range(0, 2));
      ck = 8'((256 - (sum % 256)) % 256);
      if ($urandom_range(0, 9) < 3) ck = ck ^ 8'($urandom_range(1, 255));
      do_load(ck, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_rst_wins();
    test_bad_checksum();
    test_gaps();
    test_zero_len();
    test_reset_mid_load();
    test_max_len();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/carregador_programa.md
Name: carregador_programa

Overview:
- Boot-time program loader that sits directly upstream of the instruction memory (BancoInstrucao) and the nRisc core.
- Accepts a byte stream over a valid/ready handshake and writes it into instruction memory starting at address 0.
- Verifies a trailing two's-complement checksum.
- Holds the core while loading; releases it only after a successful load.

Parameters:
- LARGURA_DADO, 8, width of instruction bytes and of the stream data.
- LARGURA_END, 8, width of the instruction-memory address.
- USA_CHECKSUM, 1, 1 = a checksum byte follows the payload and is verified; 0 = no checksum phase.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset.
- carregar  input  1  load request; sampled in OCIOSO, EXECUTA and ERRO only.
- comprimento  input  LARGURA_END  payload length in bytes; latched when carregar is accepted.
- in_valid  input  1  stream byte valid.
- in_data  input  LARGURA_DADO  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_escreve  output  1  instruction-memory write strobe, one-cycle pulse per payload byte.
- mem_endereco  output  LARGURA_END  write address.
- mem_dado  output  LARGURA_DADO  write data.
- segura_cpu  output  1  1 = core held (PC forced to 0, no fetch).
- pronto  output  1  program loaded and core running.
- erro  output  1  checksum mismatch.

Behaviour:
- Reset (synchronous, active-high, any state):
  - state=OCIOSO, segura_cpu=1, in_ready=0, mem_escreve=0, mem_endereco=0, mem_dado=0, pronto=0, erro=0.
  - Internal ptr=0, restante=0, soma=0.
- Transfer occurs when in_valid && in_ready. in_data is sampled only on a transfer.
- in_ready is combinational from state: 1 in CARREGA and CHECA, else 0.
- OCIOSO (carregar=1):
  - Latch restante=comprimento; clear ptr=0 and soma=0.
  - If comprimento==0, go to EXECUTA (no writes, no checksum byte consumed). Otherwise go to CARREGA.
- CARREGA, on each transfer:
  - Next cycle: mem_escreve=1, mem_endereco=ptr, mem_dado=in_data. Write latency is 1 cycle; back-to-back transfers give one write every cycle.
  - ptr increments, soma = (soma + in_data) mod 256, restante decrements.
  - On the transfer where restante==1: go to CHECA if USA_CHECKSUM=1, else to EXECUTA.
  - mem_escreve=0 in every cycle without a preceding transfer. mem_endereco and mem_dado hold their last value.
- CHECA, on a transfer:
  - If (soma + in_data) mod 256 == 0, go to EXECUTA. Otherwise go to ERRO.
  - The checksum byte is never written to memory.
- EXECUTA: segura_cpu=0, pronto=1, erro=0.
  - carregar=1 restarts a load: the next cycle has segura_cpu=1, pronto=0, same entry rules as OCIOSO.
- ERRO: erro=1, segura_cpu=1, pronto=0.
  - carregar=1 clears erro and restarts the load (OCIOSO entry rules).
- carregar is ignored in CARREGA and CHECA.
- Outputs segura_cpu, pronto and erro are registered. They change in the cycle after the state transition that causes them.
- Boundary cases:
  - comprimento=255 writes addresses 0..254. ptr never wraps, since the maximum is 254.
  - RST during CARREGA/CHECA aborts the load; already-written memory is left untouched. A subsequent load restarts at address 0.
  - in_valid held with in_ready=0 (OCIOSO/EXECUTA/ERRO) consumes nothing.
  - Simultaneous RST and carregar: RST wins.

Decomposition:
- Shared package holds:
  - state encoding: OCIOSO=0, CARREGA=1, CHECA=2, EXECUTA=3, ERRO=4 (3 bits);
  - LARGURA_DADO/LARGURA_END defaults, shared with BancoInstrucao and nRisc.
- One sub-module is natural: acumulador_checksum (CLK, RST, clear, enable, byte → soma, a mod-256 accumulator).
- The FSM, address counter and handshake live in the top.

Test Plan:
1. Assert RST for 2 cycles → segura_cpu=1, pronto=0, erro=0, in_ready=0, mem_escreve=0, mem_endereco=0.
2. carregar, comprimento=3; bytes 0x21,0x42,0x63 back-to-back, then 0x3A → three consecutive mem_escreve pulses writing (0,0x21), (1,0x42), (2,0x63); pronto=1, segura_cpu=0 after checksum accepted.
3. Same load with checksum 0x3B → erro=1, segura_cpu=1, pronto=0. Then carregar with a correct stream → erro clears next cycle; load succeeds.
4. comprimento=4, in_valid toggled 1,0,0,1,1,0,1 then checksum → writes only on transfer cycles; addresses 0,1,2,3 with no gaps or duplicates.
5. carregar with comprimento=0 → EXECUTA next cycle; no mem_escreve; in_ready never 1; pronto=1.
6. RST after 2 of 4 bytes → no further writes, state OCIOSO, segura_cpu=1. A new load of 0x11,0x22 (checksum 0xCD) writes addresses 0 and 1.
